// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer for the core.
// Single-outstanding imem handshake with decode stall and redirect flush.

module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        stall_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] ir_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  logic [2:0]  state;
  logic [2:0]  state_nx;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_pc_nx;
  logic [31:0] tgt;
  logic        load;
  logic        flush;
  logic        slot_free;
  logic        drop;

  assign tgt       = redirect_pc_i & 32'hFFFF_FFFC;
  assign flush     = redirect_i;
  assign slot_free = !valid_o || !stall_i;
  assign drop      = valid_o && !stall_i && !flush && !load;

  assign imem_req_o  = (state == S_REQ);
  assign imem_addr_o = fetch_pc;

  always_comb begin
    state_nx    = state;
    fetch_pc_nx = fetch_pc;
    load        = 1'b0;
    if (flush) begin
      fetch_pc_nx = tgt;
      unique case (state)
        S_IDLE:  state_nx = S_REQ;
        S_HOLD:  state_nx = S_REQ;
        S_REQ:   state_nx = imem_gnt_i ? S_DRAIN : S_REQ;
        // a response landing with the redirect closes the old request
        S_WAIT:  state_nx = imem_rvalid_i ? S_REQ : S_DRAIN;
        S_DRAIN: state_nx = imem_rvalid_i ? S_REQ : S_DRAIN;
        default: state_nx = S_REQ;
      endcase
    end else begin
      unique case (state)
        S_IDLE: state_nx = S_REQ;
        S_REQ: begin
          if (imem_gnt_i) state_nx = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid_i) begin
            load        = 1'b1;
            fetch_pc_nx = fetch_pc + 32'd4;
            state_nx    = slot_free ? S_REQ : S_HOLD;
          end
        end
        S_HOLD: begin
          if (!stall_i) state_nx = S_REQ;
        end
        S_DRAIN: begin
          if (imem_rvalid_i) state_nx = S_REQ;
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_PC;
    end else begin
      state    <= state_nx;
      fetch_pc <= fetch_pc_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o <= 1'b0;
      pc_o    <= 32'd0;
      ir_o    <= 32'd0;
    end else begin
      unique case (1'b1)
        flush: valid_o <= 1'b0;
        load: begin
          valid_o <= 1'b1;
          pc_o    <= fetch_pc;
          ir_o    <= imem_rdata_i;
        end
        drop:    valid_o <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: randomized scoreboard bench for fetch_ctrl.
// Memory returns addr^0xA5A5_0000 so ir_o also proves the fetch address.

module tb_fetch_ctrl;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'd0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'd0;
  logic        stall_i = 1'b0;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [31:0] ir_o;

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_PC(RPC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .stall_i       (stall_i),
    .valid_o       (valid_o),
    .pc_o          (pc_o),
    .ir_o          (ir_o)
  );

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] ir;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;

  // reference model: fetch pointer, in-flight bookkeeping, output slot
  bit          m_started, m_inflight, m_stale, m_hold, m_valid;
  logic [31:0] m_pc, m_opc, m_oir;

  // memory environment
  bit          e_pend, g_prev, r_prev;
  int          e_cnt;
  logic [31:0] e_addr, a_prev;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL scoreboard: got empty queue expected entry");
      end else begin
        e = exp_q.pop_front();
        chk("imem_req_o", 32'(imem_req_o), 32'(e.req));
        if (e.req) chk("imem_addr_o", imem_addr_o, e.addr);
        chk("valid_o", 32'(valid_o), 32'(e.valid));
        if (e.valid) begin
          chk("pc_o", pc_o, e.pc);
          chk("ir_o", ir_o, e.ir);
        end
      end
    end
  end

  task automatic model_init();
    m_started = 0; m_inflight = 0; m_stale = 0;
    m_hold = 0; m_valid = 0;
    m_pc = RPC; m_opc = 32'd0; m_oir = 32'd0;
    e_pend = 0; e_cnt = 0; g_prev = 0; r_prev = 0;
    e_addr = 32'd0; a_prev = 32'd0;
  endtask

  // entered and left 2 time units after a rising edge
  task automatic cyc(input bit s, input bit r, input logic [31:0] t,
                     input bit g, input int lat);
    bit   rv, fire, resp, ld;
    exp_t e;
    if (g_prev && r_prev) begin
      e_pend = 1;
      e_addr = a_prev;
      e_cnt  = (lat < 0) ? int'($urandom_range(0, 2)) : lat;
    end
    rv = e_pend && (e_cnt == 0);
    stall_i       = s;
    redirect_i    = r;
    redirect_pc_i = t;
    imem_gnt_i    = g;
    imem_rvalid_i = rv;
    imem_rdata_i  = rv ? (e_addr ^ KEY) : $urandom();
    if (rv) e_pend = 0;
    else if (e_pend) e_cnt--;
    r_prev = imem_req_o;
    a_prev = imem_addr_o;
    g_prev = g;

    fire = m_started && !m_inflight && !m_hold && g;
    resp = m_inflight && rv;
    ld   = 0;
    if (r) begin
      m_pc      = t & 32'hFFFF_FFFC;
      m_valid   = 0;
      m_hold    = 0;
      m_started = 1;
      if (fire) begin
        m_inflight = 1;
        m_stale    = 1;
      end else if (m_inflight) begin
        if (resp) begin
          m_inflight = 0;
          m_stale    = 0;
        end else begin
          m_stale = 1;
        end
      end
    end else begin
      if (!m_started) m_started = 1;
      else if (fire) begin
        m_inflight = 1;
        m_stale    = 0;
      end else if (resp) begin
        m_inflight = 0;
        if (!m_stale) begin
          ld     = 1;
          m_hold = m_valid && s;
        end
        m_stale = 0;
      end else if (m_hold && !s) m_hold = 0;
      if (ld) begin
        m_valid = 1;
        m_opc   = m_pc;
        m_oir   = m_pc ^ KEY;
        m_pc    = m_pc + 32'd4;
      end else if (m_valid && !s) m_valid = 0;
    end

    e.req   = m_started && !m_inflight && !m_hold;
    e.addr  = m_pc;
    e.valid = m_valid;
    e.pc    = m_opc;
    e.ir    = m_oir;
    exp_q.push_back(e);
    mon_en = 1;
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"}, 32'(imem_req_o), 32'd0);
    chk({tag, "_valid"}, 32'(valid_o), 32'd0);
    chk({tag, "_pc"}, pc_o, 32'd0);
    chk({tag, "_ir"}, ir_o, 32'd0);
    chk({tag, "_addr"}, imem_addr_o, RPC);
  endtask

  task automatic do_reset();
    #3;
    rst_n = 0;
    mon_en = 0;
    exp_q.delete();
    stall_i = 0; redirect_i = 0; imem_gnt_i = 0; imem_rvalid_i = 0;
    #1;
    check_reset_outputs("async_reset");
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1;
    model_init();
  endtask

  task automatic until_wait(input int lat);
    for (int i = 0; i < 12 && !(m_inflight && !m_stale); i++)
      cyc(0, 0, 32'd0, 1, lat);
  endtask

  initial begin
    model_init();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    #1;
    rst_n = 1;

    repeat (8) cyc(0, 0, 32'd0, 1, 0);
    repeat (5) cyc(1, 0, 32'd0, 1, 0);
    repeat (4) cyc(0, 0, 32'd0, 1, 0);

    until_wait(2);
    cyc(0, 1, 32'h0000_2002, 0, 2);
    repeat (8) cyc(0, 0, 32'd0, 1, 0);

    until_wait(0);
    cyc(0, 1, 32'h0000_3000, 1, 0);
    repeat (6) cyc(0, 0, 32'd0, 1, 0);

    cyc(0, 1, 32'hFFFF_FFFC, 1, 0);
    repeat (8) cyc(0, 0, 32'd0, 1, 0);

    until_wait(2);
    do_reset();
    repeat (6) cyc(0, 0, 32'd0, 1, 0);

    for (int i = 0; i < 3000; i++) begin
      automatic logic [31:0] t =
        ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : $urandom();
      cyc($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, t,
          $urandom_range(0, 3) != 0, -1);
      if ($urandom_range(0, 999) == 0) do_reset();
    end

    mon_en = 0;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
